// File: rtl/pipelined_control_unit_if.sv
// pipelined_control_unit_if: ID-stage inputs and pipeline control outputs of the control unit
interface pipelined_control_unit_if #(
    parameter int OP_CODE_SIZE  = 4,
    parameter int ALU_OP_SIZE   = 2,
    parameter int REG_ADDR_BITS = 3
);
    logic                     id_valid;
    logic [OP_CODE_SIZE-1:0]  id_opcode;
    logic [REG_ADDR_BITS-1:0] id_rs;
    logic [REG_ADDR_BITS-1:0] id_rt;
    logic [REG_ADDR_BITS-1:0] id_rd;
    logic                     hold_i;
    logic                     ex_branch_taken;
    logic                     ex_valid;
    logic [8:0]               ex_ctrl;
    logic [ALU_OP_SIZE-1:0]   ex_alu_op;
    logic [REG_ADDR_BITS-1:0] ex_dst;
    logic                     mem_valid;
    logic [8:0]               mem_ctrl;
    logic [REG_ADDR_BITS-1:0] mem_dst;
    logic                     wb_we;
    logic                     wb_mem_to_reg;
    logic [REG_ADDR_BITS-1:0] wb_dst;
    logic                     stall_o;
    logic                     flush_o;
    logic                     ex_illegal;

    modport master (
        output id_valid, id_opcode, id_rs, id_rt, id_rd, hold_i, ex_branch_taken,
        input  ex_valid, ex_ctrl, ex_alu_op, ex_dst, mem_valid, mem_ctrl, mem_dst,
               wb_we, wb_mem_to_reg, wb_dst, stall_o, flush_o, ex_illegal
    );

    modport slave (
        input  id_valid, id_opcode, id_rs, id_rt, id_rd, hold_i, ex_branch_taken,
        output ex_valid, ex_ctrl, ex_alu_op, ex_dst, mem_valid, mem_ctrl, mem_dst,
               wb_we, wb_mem_to_reg, wb_dst, stall_o, flush_o, ex_illegal
    );
endinterface

// File: rtl/pipelined_control_unit.sv
// pipelined_control_unit: opcode decode, ID/EX-EX/MEM-MEM/WB control pipeline, load-use stall and branch flush
module pipelined_control_unit #(
    parameter int OP_CODE_SIZE   = 4,
    parameter int ALU_OP_SIZE    = 2,
    parameter int REG_ADDR_BITS  = 3,
    parameter int ILLEGAL_AS_NOP = 1
) (
    input logic clk,
    input logic rst_n,
    pipelined_control_unit_if.slave bus
);
    // control bundle bits: {bne,we,mem_to_reg,reg_dst,alu_src,mem_write,mem_read,beq,jump}
    localparam logic [8:0] C_LW   = 9'b0_1_1_0_1_0_1_0_0;
    localparam logic [8:0] C_SW   = 9'b0_0_0_0_1_1_0_0_0;
    localparam logic [8:0] C_DP   = 9'b0_1_0_1_0_0_0_0_0;
    localparam logic [8:0] C_BEQ  = 9'b0_0_0_0_0_0_0_1_0;
    localparam logic [8:0] C_BNE  = 9'b1_0_0_0_0_0_0_0_0;
    localparam logic [8:0] C_J    = 9'b0_0_0_0_0_0_0_0_1;
    localparam logic [ALU_OP_SIZE-1:0] ALU_DP  = ALU_OP_SIZE'(2'b00);
    localparam logic [ALU_OP_SIZE-1:0] ALU_CMP = ALU_OP_SIZE'(2'b01);
    localparam logic [ALU_OP_SIZE-1:0] ALU_ADR = ALU_OP_SIZE'(2'b10);
    localparam logic NOP_ILL = (ILLEGAL_AS_NOP != 0);

    logic [8:0]               d_ctrl;
    logic [ALU_OP_SIZE-1:0]   d_alu;
    logic                     d_ill;
    logic [REG_ADDR_BITS-1:0] d_dst;
    logic                     upper_bad;
    logic                     take;
    logic                     keep;

    logic                     ex_valid_q, ex_ill_q, mem_valid_q, wb_valid_q, wb_we_q, wb_m2r_q;
    logic [8:0]               ex_ctrl_q, mem_ctrl_q;
    logic [ALU_OP_SIZE-1:0]   ex_alu_q;
    logic [REG_ADDR_BITS-1:0] ex_dst_q, mem_dst_q, wb_dst_q;

    assign upper_bad = (bus.id_opcode >> 4) != '0;

    // decode the low opcode nibble; illegal codes become a bubble or data-proc depending on ILLEGAL_AS_NOP
    always_comb begin
        d_ctrl = C_DP;
        d_alu  = ALU_DP;
        d_ill  = upper_bad;
        case (bus.id_opcode[3:0])
            4'b0000: begin d_ctrl = C_LW;  d_alu = ALU_ADR; end
            4'b0001: begin d_ctrl = C_SW;  d_alu = ALU_ADR; end
            4'b1010, 4'b1110, 4'b1111: d_ill = 1'b1;
            4'b1011: begin d_ctrl = C_BEQ; d_alu = ALU_CMP; end
            4'b1100: begin d_ctrl = C_BNE; d_alu = ALU_CMP; end
            4'b1101: begin d_ctrl = C_J;   d_alu = ALU_DP;  end
            default: ;
        endcase
        if (d_ill) begin
            d_ctrl = NOP_ILL ? 9'd0 : C_DP;
            d_alu  = ALU_DP;
        end
    end

    assign d_dst = d_ctrl[5] ? bus.id_rd : bus.id_rt;

    assign bus.flush_o = !bus.hold_i && bus.ex_branch_taken && ex_valid_q;
    // a squashed instruction must not also freeze the front end, so flush masks the stall
    assign bus.stall_o = !bus.hold_i && !bus.flush_o && ex_valid_q && ex_ctrl_q[2] && bus.id_valid &&
                         ex_dst_q != '0 && (ex_dst_q == bus.id_rs || ex_dst_q == bus.id_rt);

    assign take = bus.id_valid && !bus.flush_o && !bus.stall_o;
    assign keep = take && !(d_ill && NOP_ILL);

    // advance all three stage registers on every non-hold edge; ID/EX takes decode or a bubble
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid_q  <= 1'b0;
            ex_ctrl_q   <= '0;
            ex_alu_q    <= '0;
            ex_dst_q    <= '0;
            ex_ill_q    <= 1'b0;
            mem_valid_q <= 1'b0;
            mem_ctrl_q  <= '0;
            mem_dst_q   <= '0;
            wb_valid_q  <= 1'b0;
            wb_we_q     <= 1'b0;
            wb_m2r_q    <= 1'b0;
            wb_dst_q    <= '0;
        end else if (!bus.hold_i) begin
            ex_valid_q  <= keep;
            ex_ctrl_q   <= keep ? d_ctrl : '0;
            ex_alu_q    <= keep ? d_alu : '0;
            ex_dst_q    <= keep ? d_dst : '0;
            ex_ill_q    <= take && d_ill && NOP_ILL;
            mem_valid_q <= ex_valid_q;
            mem_ctrl_q  <= ex_ctrl_q;
            mem_dst_q   <= ex_dst_q;
            wb_valid_q  <= mem_valid_q;
            wb_we_q     <= mem_ctrl_q[7];
            wb_m2r_q    <= mem_ctrl_q[6];
            wb_dst_q    <= mem_dst_q;
        end
    end

    assign bus.ex_valid      = ex_valid_q;
    assign bus.ex_ctrl       = ex_ctrl_q;
    assign bus.ex_alu_op     = ex_alu_q;
    assign bus.ex_dst        = ex_dst_q;
    assign bus.ex_illegal    = ex_ill_q;
    assign bus.mem_valid     = mem_valid_q;
    assign bus.mem_ctrl      = {mem_ctrl_q[8:4], mem_ctrl_q[3:2] & {2{mem_valid_q}}, mem_ctrl_q[1:0]};
    assign bus.mem_dst       = mem_dst_q;
    assign bus.wb_we         = wb_valid_q && wb_we_q;
    assign bus.wb_mem_to_reg = wb_valid_q && wb_m2r_q;
    assign bus.wb_dst        = wb_dst_q;
endmodule

// File: tb/tb_pipelined_control_unit.sv
// tb_pipelined_control_unit: table-driven, hand-sequenced and random checks of the control pipeline
module tb_pipelined_control_unit;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pipelined_control_unit_if #(.OP_CODE_SIZE(4), .ALU_OP_SIZE(2), .REG_ADDR_BITS(3)) b1 ();
    pipelined_control_unit_if #(.OP_CODE_SIZE(4), .ALU_OP_SIZE(2), .REG_ADDR_BITS(3)) b2 ();

    pipelined_control_unit #(.OP_CODE_SIZE(4), .ALU_OP_SIZE(2), .REG_ADDR_BITS(3), .ILLEGAL_AS_NOP(1))
        dut (.clk(clk), .rst_n(rst_n), .bus(b1.slave));
    pipelined_control_unit #(.OP_CODE_SIZE(4), .ALU_OP_SIZE(2), .REG_ADDR_BITS(3), .ILLEGAL_AS_NOP(0))
        dut2 (.clk(clk), .rst_n(rst_n), .bus(b2.slave));

    assign b2.id_valid        = b1.id_valid;
    assign b2.id_opcode       = b1.id_opcode;
    assign b2.id_rs           = b1.id_rs;
    assign b2.id_rt           = b1.id_rt;
    assign b2.id_rd           = b1.id_rd;
    assign b2.hold_i          = b1.hold_i;
    assign b2.ex_branch_taken = b1.ex_branch_taken;

    typedef struct packed {
        logic       v;
        logic [8:0] c;
        logic [1:0] a;
        logic [2:0] d;
        logic       il;
    } st_t;

    typedef struct {
        logic [3:0] op;
        logic [8:0] c;
        logic [1:0] a;
        logic       il;
    } vec_t;

    vec_t tab[16];
    st_t  m_ex, m_mem, m_wb;
    int   total = 0;
    int   bad = 0;
    logic es = 1'b0;
    logic ef = 1'b0;

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", n, act, exp, $time);
        end
    endtask

    function automatic st_t dec(input logic [3:0] op, input logic [2:0] rt, input logic [2:0] rd);
        st_t s;
        s.v  = !tab[op].il;
        s.c  = tab[op].c;
        s.a  = tab[op].a;
        s.il = tab[op].il;
        s.d  = tab[op].il ? 3'd0 : (tab[op].c[5] ? rd : rt);
        return s;
    endfunction

    task automatic check_all();
        chk("ex_valid", b1.ex_valid, m_ex.v);
        chk("ex_ctrl", b1.ex_ctrl, m_ex.c);
        chk("ex_alu_op", b1.ex_alu_op, m_ex.a);
        chk("ex_dst", b1.ex_dst, m_ex.d);
        chk("ex_illegal", b1.ex_illegal, m_ex.il);
        chk("mem_valid", b1.mem_valid, m_mem.v);
        chk("mem_ctrl", b1.mem_ctrl, m_mem.c & {5'h1f, {2{m_mem.v}}, 2'b11});
        chk("mem_dst", b1.mem_dst, m_mem.d);
        chk("wb_we", b1.wb_we, m_wb.v & m_wb.c[7]);
        chk("wb_mem_to_reg", b1.wb_mem_to_reg, m_wb.v & m_wb.c[6]);
        chk("wb_dst", b1.wb_dst, m_wb.d);
    endtask

    task automatic step(input logic v, input logic [3:0] op, input logic [2:0] rs, input logic [2:0] rt,
                        input logic [2:0] rd, input logic h, input logic br);
        b1.id_valid = v;
        b1.id_opcode = op;
        b1.id_rs = rs;
        b1.id_rt = rt;
        b1.id_rd = rd;
        b1.hold_i = h;
        b1.ex_branch_taken = br;
        ef = !h && br && m_ex.v;
        es = !h && !ef && m_ex.v && m_ex.c[2] && v && m_ex.d != 3'd0 && (m_ex.d == rs || m_ex.d == rt);
        @(negedge clk);
        chk("stall_o", b1.stall_o, es);
        chk("flush_o", b1.flush_o, ef);
        @(posedge clk);
        if (!h) begin
            m_wb  = m_mem;
            m_mem = m_ex;
            m_ex  = (v && !es && !ef) ? dec(op, rt, rd) : '0;
        end
        #1;
        check_all();
    endtask

    task automatic idle();
        step(1'b0, 4'd0, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0);
    endtask

    initial begin
        logic       rv, rh, rb;
        logic [3:0] rop;
        logic [2:0] rrs, rrt, rrd;
        for (int i = 0; i < 16; i++) begin
            tab[i].op = 4'(i);
            tab[i].c  = 9'b0_1_0_1_0_0_0_0_0;
            tab[i].a  = 2'b00;
            tab[i].il = 1'b0;
        end
        tab[0].c  = 9'b0_1_1_0_1_0_1_0_0;  tab[0].a  = 2'b10;
        tab[1].c  = 9'b0_0_0_0_1_1_0_0_0;  tab[1].a  = 2'b10;
        tab[11].c = 9'b0_0_0_0_0_0_0_1_0;  tab[11].a = 2'b01;
        tab[12].c = 9'b1_0_0_0_0_0_0_0_0;  tab[12].a = 2'b01;
        tab[13].c = 9'b0_0_0_0_0_0_0_0_1;
        foreach (tab[i]) if (i == 10 || i == 14 || i == 15) begin tab[i].c = '0; tab[i].il = 1'b1; end
        m_ex = '0; m_mem = '0; m_wb = '0;
        b1.id_valid = 0; b1.id_opcode = 0; b1.id_rs = 0; b1.id_rt = 0; b1.id_rd = 0;
        b1.hold_i = 0; b1.ex_branch_taken = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        check_all();

        // reset mid-stream with LW sitting in EX/MEM
        step(1, 4'd0, 3'd1, 3'd5, 3'd0, 0, 0);
        step(1, 4'd2, 3'd0, 3'd0, 3'd4, 0, 0);
        chk("rst_pre_mem_valid", b1.mem_valid, 1);
        rst_n = 1'b0;
        #2;
        chk("rst_mem_valid", b1.mem_valid, 0);
        chk("rst_mem_ctrl", b1.mem_ctrl, 0);
        chk("rst_ex_valid", b1.ex_valid, 0);
        chk("rst_wb_we", b1.wb_we, 0);
        chk("rst_stall", b1.stall_o, 0);
        m_ex = '0; m_mem = '0; m_wb = '0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        step(1, 4'd1, 3'd2, 3'd3, 3'd0, 0, 0);
        chk("rst_first_ctrl", b1.ex_ctrl, 9'b0_0_0_0_1_1_0_0_0);

        // load-use: LW r3 then ADD rs=3 stalls one cycle, then re-presents
        step(1, 4'd0, 3'd1, 3'd3, 3'd0, 0, 0);
        step(1, 4'd2, 3'd3, 3'd0, 3'd6, 0, 0);
        chk("lu_stall_seen", es, 1);
        chk("lu_bubble", b1.ex_valid, 0);
        step(1, 4'd2, 3'd3, 3'd0, 3'd6, 0, 0);
        chk("lu_add_valid", b1.ex_valid, 1);
        chk("lu_add_dst", b1.ex_dst, 6);
        chk("lu_wb_we", b1.wb_we, 1);
        chk("lu_wb_dst", b1.wb_dst, 3);

        // flush overrides a load-use conflict; flush behind a BEQ
        step(1, 4'd0, 3'd0, 3'd2, 3'd0, 0, 0);
        step(1, 4'd2, 3'd2, 3'd0, 3'd1, 0, 1);
        chk("fl_ex_bubble", b1.ex_valid, 0);
        step(1, 4'd11, 3'd1, 3'd2, 3'd0, 0, 0);
        step(1, 4'd3, 3'd1, 3'd1, 3'd7, 0, 1);
        chk("fl_beq_bubble", b1.ex_ctrl, 0);

        // hold three cycles with SW in EX/MEM
        step(1, 4'd1, 3'd1, 3'd4, 3'd0, 0, 0);
        idle();
        for (int i = 0; i < 3; i++) step(1, 4'd0, 3'd0, 3'd7, 3'd0, 1, 1);
        chk("hold_mem_ctrl", b1.mem_ctrl, 9'b0_0_0_0_1_1_0_0_0);
        idle();
        chk("hold_resume_wb_dst", b1.wb_dst, 4);

        // illegal opcode: bubble+flag on default build, data-proc when ILLEGAL_AS_NOP=0
        step(1, 4'd14, 3'd1, 3'd2, 3'd5, 0, 0);
        chk("ill_valid", b1.ex_valid, 0);
        chk("ill_flag", b1.ex_illegal, 1);
        chk("ill2_ctrl", b2.ex_ctrl, 9'b0_1_0_1_0_0_0_0_0);
        chk("ill2_valid", b2.ex_valid, 1);
        chk("ill2_flag", b2.ex_illegal, 0);
        idle();
        chk("ill_clear", b1.ex_illegal, 0);

        // full decode sweep from the table
        for (int i = 0; i < 16; i++) begin
            step(1, tab[i].op, 3'd1, 3'd0, 3'(i), 0, 0);
            chk("sweep_ctrl", b1.ex_ctrl, tab[i].c);
            chk("sweep_alu", b1.ex_alu_op, tab[i].a);
            chk("sweep_ill", b1.ex_illegal, tab[i].il);
        end
        idle();
        idle();

        // random traffic; a predicted stall re-presents the same ID instruction
        rv = 0; rop = 0; rrs = 0; rrt = 0; rrd = 0;
        for (int n = 0; n < 400; n++) begin
            if (!es) begin
                rv  = ($urandom % 5) != 0;
                rop = 4'($urandom % 16);
                rrs = 3'($urandom % 8);
                rrt = 3'($urandom % 8);
                rrd = 3'($urandom % 8);
            end
            rh = ($urandom % 10) == 0;
            rb = ($urandom % 8) == 0;
            step(rv, rop, rrs, rrt, rrd, rh, rb);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
